// File: rtl/qp_mem_arb.sv
module qp_mem_arb #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wbs_mode,

  input  logic                             wbs_req,
  input  logic                             wbs_we,
  input  logic [ADDR_W-1:0]                wbs_addr,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_wdata,
  output logic                             wbs_ack,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_rdata,

  input  logic                             core_req,
  input  logic                             core_we,
  input  logic [ADDR_W-1:0]                core_addr,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0] core_wdata,
  output logic                             core_ack,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] core_rdata,

  output logic                             mem_csb0,
  output logic                             mem_web0,
  output logic [ADDR_W-1:0]                mem_addr0,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] mem_din0,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0] mem_dout0,

  output logic                             busy
);

  localparam int PW = PATCH_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic              host_win_q, host_win_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [PW-1:0]     lat_wdata_q, lat_wdata_d;
  logic [2:0]        starve_cnt_q, starve_cnt_d;

  logic              mem_csb0_q, mem_csb0_d;
  logic              mem_web0_q, mem_web0_d;
  logic [ADDR_W-1:0] mem_addr0_q, mem_addr0_d;
  logic [PW-1:0]     mem_din0_q, mem_din0_d;
  logic              wbs_ack_q, wbs_ack_d;
  logic              core_ack_q, core_ack_d;
  logic [PW-1:0]     wbs_rdata_q, wbs_rdata_d;
  logic [PW-1:0]     core_rdata_q, core_rdata_d;
  logic              busy_q, busy_d;

  logic              host_pick;
  logic              starved;

  assign starved   = (starve_cnt_q == 3'(STARVE_MAX));
  assign host_pick = wbs_req && (wbs_mode || !core_req || starved);

  // Memory strobes and acks are registered from the state they belong to,
  // so they trail the state register by one cycle: the select lands one
  // edge after the grant and the ack one edge after that.
  always_comb begin
    state_d      = state_q;
    host_win_d   = host_win_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    starve_cnt_d = starve_cnt_q;
    mem_csb0_d   = 1'b1;
    mem_web0_d   = 1'b1;
    mem_addr0_d  = mem_addr0_q;
    mem_din0_d   = mem_din0_q;
    wbs_ack_d    = 1'b0;
    core_ack_d   = 1'b0;
    wbs_rdata_d  = wbs_rdata_q;
    core_rdata_d = core_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (wbs_req || core_req) begin
          state_d    = ACCESS;
          host_win_d = host_pick;
          if (host_pick) begin
            lat_we_d     = wbs_we;
            lat_addr_d   = wbs_addr;
            lat_wdata_d  = wbs_wdata;
            starve_cnt_d = '0;
          end else begin
            lat_we_d    = core_we;
            lat_addr_d  = core_addr;
            lat_wdata_d = core_wdata;
            if (wbs_req && !starved) begin
              starve_cnt_d = starve_cnt_q + 3'd1;
            end
          end
        end
      end
      ACCESS: begin
        state_d     = RESP;
        mem_csb0_d  = 1'b0;
        mem_web0_d  = ~lat_we_q;
        mem_addr0_d = lat_addr_q;
        mem_din0_d  = lat_wdata_q;
      end
      RESP: begin
        state_d    = IDLE;
        wbs_ack_d  = host_win_q;
        core_ack_d = ~host_win_q;
      end
      default: state_d = IDLE;
    endcase

    // Read data from the SRAM is valid during the ack cycle.
    if (wbs_ack_q && !lat_we_q) begin
      wbs_rdata_d = mem_dout0;
    end
    if (core_ack_q && !lat_we_q) begin
      core_rdata_d = mem_dout0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      host_win_q   <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      starve_cnt_q <= '0;
      mem_csb0_q   <= 1'b1;
      mem_web0_q   <= 1'b1;
      mem_addr0_q  <= '0;
      mem_din0_q   <= '0;
      wbs_ack_q    <= 1'b0;
      core_ack_q   <= 1'b0;
      wbs_rdata_q  <= '0;
      core_rdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      host_win_q   <= host_win_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      starve_cnt_q <= starve_cnt_d;
      mem_csb0_q   <= mem_csb0_d;
      mem_web0_q   <= mem_web0_d;
      mem_addr0_q  <= mem_addr0_d;
      mem_din0_q   <= mem_din0_d;
      wbs_ack_q    <= wbs_ack_d;
      core_ack_q   <= core_ack_d;
      wbs_rdata_q  <= wbs_rdata_d;
      core_rdata_q <= core_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_csb0   = mem_csb0_q;
  assign mem_web0   = mem_web0_q;
  assign mem_addr0  = mem_addr0_q;
  assign mem_din0   = mem_din0_q;
  assign wbs_ack    = wbs_ack_q;
  assign core_ack   = core_ack_q;
  assign wbs_rdata  = wbs_rdata_q;
  assign core_rdata = core_rdata_q;
  assign busy       = busy_q;

endmodule
